// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the arbiter, the two pipeline requesters (IF fetch and
// MEM load/store) and the single-ported unified memory.
//   slave  : arbiter view
//   master : environment view (pipeline + memory)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              start_i;

    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_valid_o;

    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_valid_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    logic              stall_o;
    logic              err_o;

    modport slave (
        input  start_i,
        input  if_req_i, if_addr_i,
        output if_rdata_o, if_valid_o,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output d_rdata_o, d_valid_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i,
        output stall_o, err_o
    );

    modport master (
        output start_i,
        output if_req_i, if_addr_i,
        input  if_rdata_o, if_valid_o,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  d_rdata_o, d_valid_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i,
        input  stall_o, err_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and
// the load/store path. Data accesses win over fetches; a one-cycle
// turnaround follows every completion while the stale request drops.
// Optional performance counters: define MEM_ARB_PERF_CNT_EN.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   ST_IDLE   | no access in flight, grant on next eligible request
//   ST_BUSY_D | data access (load/store) outstanding on memory
//   ST_BUSY_I | instruction fetch outstanding on memory
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    mem_port_arbiter_if.slave       bus
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]             cnt_if_o,
    output logic [31:0]             cnt_d_o,
    output logic [31:0]             cnt_conflict_o
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_D = 2'd1;
    localparam logic [1:0] ST_BUSY_I = 2'd2;

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [1:0]      state;
    logic [WD_W-1:0] wd_cnt;

    logic d_elig;
    logic if_elig;
    logic grant_ok;
    logic wd_expired;

    // A requester whose completion pulse is visible is still holding a stale
    // request; no grant at all happens while either pulse is up (turnaround).
    assign d_elig     = bus.d_req_i  & ~bus.d_valid_o;
    assign if_elig    = bus.if_req_i & ~bus.if_valid_o;
    assign grant_ok   = bus.start_i & ~bus.d_valid_o & ~bus.if_valid_o;
    assign wd_expired = (TIMEOUT != 0) && (wd_cnt == WD_W'(TIMEOUT - 1));

    // Pipeline freeze while any request has not yet seen its completion.
    assign bus.stall_o = ~rst_i & (if_elig | d_elig);

    // Grant / completion FSM with memory-side output registers and watchdog.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= ST_IDLE;
            wd_cnt          <= '0;
            bus.mem_req_o   <= 1'b0;
            bus.mem_we_o    <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_wdata_o <= '0;
            bus.if_rdata_o  <= '0;
            bus.if_valid_o  <= 1'b0;
            bus.d_rdata_o   <= '0;
            bus.d_valid_o   <= 1'b0;
            bus.err_o       <= 1'b0;
        end else begin
            bus.if_valid_o <= 1'b0;
            bus.d_valid_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wd_cnt <= '0;
                    if (grant_ok) begin
                        if (d_elig) begin
                            state           <= ST_BUSY_D;
                            bus.mem_req_o   <= 1'b1;
                            bus.mem_we_o    <= bus.d_we_i;
                            bus.mem_addr_o  <= bus.d_addr_i;
                            bus.mem_wdata_o <= bus.d_wdata_i;
                        end else if (if_elig) begin
                            state          <= ST_BUSY_I;
                            bus.mem_req_o  <= 1'b1;
                            bus.mem_we_o   <= 1'b0;
                            bus.mem_addr_o <= bus.if_addr_i;
                        end
                    end
                end
                ST_BUSY_D, ST_BUSY_I: begin
                    if (bus.mem_ack_i) begin
                        state         <= ST_IDLE;
                        wd_cnt        <= '0;
                        bus.mem_req_o <= 1'b0;
                        if (state == ST_BUSY_D) begin
                            bus.d_valid_o <= 1'b1;
                            if (!bus.mem_we_o)
                                bus.d_rdata_o <= bus.mem_rdata_i;
                        end else begin
                            bus.if_valid_o <= 1'b1;
                            bus.if_rdata_o <= bus.mem_rdata_i;
                        end
                    end else if (wd_expired) begin
                        // Abort: the requester still gets its pulse so the
                        // pipeline unfreezes, with zero data and a sticky error.
                        state         <= ST_IDLE;
                        wd_cnt        <= '0;
                        bus.mem_req_o <= 1'b0;
                        bus.err_o     <= 1'b1;
                        if (state == ST_BUSY_D) begin
                            bus.d_valid_o <= 1'b1;
                            bus.d_rdata_o <= '0;
                        end else begin
                            bus.if_valid_o <= 1'b1;
                            bus.if_rdata_o <= '0;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    wd_cnt        <= '0;
                    bus.mem_req_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic conflict;

    assign conflict = (state == ST_IDLE) & grant_ok & d_elig & if_elig;

    // Completion and conflict counters, free-running with natural wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_if_o       <= '0;
            cnt_d_o        <= '0;
            cnt_conflict_o <= '0;
        end else begin
            if (bus.if_valid_o)
                cnt_if_o <= cnt_if_o + 32'd1;
            if (bus.d_valid_o)
                cnt_d_o <= cnt_d_o + 32'd1;
            if (conflict)
                cnt_conflict_o <= cnt_conflict_o + 32'd1;
        end
    end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF-stage instruction fetch and the MEM-stage load/store path of the 5-stage pipelined CPU.
- Serialises the two requesters over a req/ack memory handshake with arbitrary latency.
- Returns read data and a one-cycle valid pulse to the winning requester.
- Drives a pipeline stall while any request is outstanding; data accesses have priority over fetches.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- DATA_W, 32, data width.
- TIMEOUT, 255, max cycles in a BUSY state without mem_ack_i before abort; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  run enable; low blocks new grants
- if_req_i  in  1  fetch request, level, held until if_valid_o
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetched instruction, registered
- if_valid_o  out  1  one-cycle completion pulse for fetch
- d_req_i  in  1  data request (MemRead|MemWrite), level, held until d_valid_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_rdata_o  out  DATA_W  load data, registered
- d_valid_o  out  1  one-cycle completion pulse for data
- mem_req_o  out  1  memory request, held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_ack_i  in  1  memory completion, one cycle
- mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i
- stall_o  out  1  freeze PC/IF_ID/ID_EX/EX_MEM
- err_o  out  1  sticky timeout flag

Behaviour:
- Reset (rst_i high at posedge):
  - State goes to IDLE.
  - All outputs and registers go to 0, including mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if_rdata_o, d_rdata_o, both valids, err_o and the watchdog counter.
- States are IDLE, BUSY_D, BUSY_I.
- IDLE, at each posedge with start_i=1:
  - An eligible d_req_i moves to BUSY_D. It latches d_addr_i, d_wdata_i and d_we_i into the mem_* output registers and sets mem_req_o=1.
  - Otherwise an eligible if_req_i moves to BUSY_I. It latches if_addr_i, sets mem_we_o=0 and mem_req_o=1.
  - A requester is ineligible in any cycle where its own valid_o is high, because its req is stale.
  - With start_i=0 the block stays in IDLE.
- BUSY_x:
  - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are held stable.
  - The watchdog counter increments each cycle.
  - At the posedge with mem_ack_i=1: mem_req_o goes to 0, state returns to IDLE and the counter clears.
  - On that same ack edge, the served requester's valid goes to 1 for exactly one cycle.
  - For a load or fetch, its rdata register captures mem_rdata_i on that edge. For a store, d_rdata_o is unchanged.
- Latency:
  - Request sampled at edge N gives mem_req_o high from N+1.
  - Ack at edge M gives valid high during cycle M+1.
  - The next grant is no earlier than edge M+2, a fixed one-cycle turnaround.
- Simultaneous if_req_i and d_req_i in IDLE: data wins, and the fetch waits.
- Fetch cannot starve:
  - The pipeline is stalled while a data request is pending, so no new data request appears.
  - The fetch is granted at the next IDLE sample.
- stall_o is combinational: (if_req_i & ~if_valid_o) | (d_req_i & ~d_valid_o). It is 0 during reset.
- mem_ack_i while in IDLE is ignored.
- Watchdog (TIMEOUT>0):
  - When the counter reaches TIMEOUT with no ack, drop mem_req_o and set err_o=1 (sticky until reset).
  - Pulse the served requester's valid with rdata=0, then return to IDLE.
- start_i falling mid-transaction: the current transaction completes normally, and no new grant follows.
- Reset mid-transaction: abort immediately to IDLE. mem_req_o is 0 from the next cycle, and any later ack is ignored.

Optional Feature:
- MEM_ARB_PERF_CNT_EN, defined: adds three 32-bit output ports, cnt_if_o, cnt_d_o and cnt_conflict_o.
  - cnt_if_o counts completed fetches.
  - cnt_d_o counts completed data accesses.
  - cnt_conflict_o counts IDLE grant cycles where both requesters were eligible.
  - All three reset to 0 and wrap at 2^32.
- Not defined: the ports and counters are absent, and the remaining behaviour is identical.

Test Plan:
- Fetch only: if_req_i=1, addr 0x0000_0010; memory acks 2 cycles after mem_req_o rises with rdata 0x0010_0093 -> mem_addr_o=0x10, mem_we_o=0; if_valid_o pulses 1 cycle with if_rdata_o=0x0010_0093; stall_o low the cycle after.
- Conflict: if_req_i and d_req_i (load, addr 0x20) rise together -> BUSY_D first with mem_addr_o=0x20; fetch granted 2 cycles after d_valid_o; perf build cnt_conflict_o=1.
- Store: d_we_i=1, addr 0x40, wdata 0xCAFE_F00D, ack after 1 cycle -> mem_we_o=1, mem_wdata_o=0xCAFE_F00D held until ack; d_valid_o pulses; d_rdata_o unchanged.
- Timeout: TIMEOUT=4, fetch with no ack -> mem_req_o drops after 4 BUSY cycles; err_o=1 and stays 1; if_valid_o pulses with if_rdata_o=0; next fetch proceeds normally.
- Reset mid-transaction: rst_i high 1 cycle while in BUSY_D -> all outputs 0 next cycle; a late mem_ack_i gives no d_valid_o.
- start_i=0 with both requests high -> no mem_req_o for 10 cycles and stall_o=1; raising start_i -> data granted first.
